char_frame_cnt: RTL and testbench
=================================

Name: char_frame_cnt

Overview:
- Parametrised successor to the fixed 16-character counter.
- Consumes a byte stream from the existing uart_rx byte receiver and counts characters up to a programmable frame length.
- Stores each received character in a small buffer that can be read back by index.
- Measures the clock cycles from first to last character of the frame, which is the timing figure the attack harness needs.
- Sits between uart_rx and the attack controller FSM.

Parameters:
- DATA_W, 8, width of one received character.
- MAX_CHARS, 16, buffer depth and largest legal frame length (power of two, 2..256).
- CNT_W, $clog2(MAX_CHARS)+1, width of count and length fields.
- TIME_W, 32, width of the frame timing counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame restart; active-high, single-cycle.
- frame_len  input  CNT_W  characters per frame (1..MAX_CHARS); sampled on the first character of a frame.
- rx_data  input  DATA_W  received character from uart_rx.
- rx_valid  input  1  one-cycle strobe marking rx_data as valid.
- count  output  CNT_W  characters accepted in the current frame.
- valid  output  1  frame complete (level); held until clear or reset.
- done  output  1  one-cycle pulse in the cycle valid rises.
- overflow  output  1  sticky; a character arrived while valid was high.
- frame_cycles  output  TIME_W  cycles from first accepted character to last, inclusive of both.
- rd_idx  input  CNT_W-1  buffer read index.
- rd_data  output  DATA_W  buffer content at rd_idx, registered with 1-cycle latency.

Behaviour:
- Reset (rst low, asynchronous) values:
  - state IDLE.
  - count 0, valid 0, done 0, overflow 0.
  - frame_cycles 0, rd_data 0.
  - Buffer contents are not reset.
- States:
  - IDLE:
    - rx_valid stores rx_data at buffer[0], count becomes 1, frame_cycles becomes 1, and frame_len is latched into len_q.
    - If len_q == 1, go to FULL; otherwise go to RUN.
    - A frame_len of 0 is treated as 1.
    - A frame_len above MAX_CHARS is clamped to MAX_CHARS.
  - RUN:
    - frame_cycles increments every cycle and saturates at all ones.
    - rx_valid writes buffer[count] and increments count.
    - When the incremented count equals len_q, go to FULL.
  - FULL:
    - valid is 1 and frame_cycles is frozen.
    - rx_valid sets overflow, and the character is dropped: no buffer write, count unchanged.
- done is asserted in the cycle after the transition into FULL, together with the first cycle of valid high.
- Latency: a character on rx_valid at cycle N is visible in count at N+1.
- clear:
  - Returns to IDLE; count, valid, done, overflow and frame_cycles go to 0.
  - clear takes priority over a simultaneous rx_valid, and that character is discarded.
- Reset mid-frame: all state is discarded immediately, with no partial-frame signalling.
- rd_data reads buffer[rd_idx] every cycle, independent of state.
  - A read and a write to the same index in the same cycle returns the old data.
  - Reading an index at or beyond count returns stale data; this is legal and no flag is raised.
- count never exceeds len_q and never wraps.

Optional Feature:
- Macro: CHAR_FRAME_TERM_EN.
- When defined:
  - Adds parameter TERM_CHAR, default 8'h0A.
  - In RUN or IDLE, a character equal to TERM_CHAR ends the frame early and is not stored or counted. The FSM enters FULL, asserts valid and done, and freezes frame_cycles at the value including that cycle.
  - Adds output term_seen (1 bit, sticky until clear/reset), marking a frame ended by the terminator.
  - A terminator arriving in IDLE yields a frame with count 0.
- When undefined: TERM_CHAR is never compared and term_seen does not exist.

Decomposition:
- Package char_pkg holds:
  - the state enum (IDLE, RUN, FULL);
  - the DATA_W default;
  - the TERM_CHAR default;
  - the clamp function for frame_len.
- One sub-module, char_buf: a MAX_CHARS x DATA_W single-write-port register file with a registered read port. It isolates the storage so it can be mapped to distributed RAM.

Test Plan:
- frame_len 16, 16 rx_valid strobes spaced 10 cycles apart:
  - count steps 1..16;
  - valid rises with a single done pulse;
  - frame_cycles = 151;
  - rd_data over idx 0..15 matches the sent bytes.
- frame_len 4, 6 characters: valid after the 4th; overflow = 1 after the 5th; count stays 4; buffer[0..3] unchanged.
- clear asserted in the same cycle as rx_valid mid-frame (count 3): next cycle count 0 and state IDLE; the byte is not stored.
- rst driven low asynchronously between clock edges while in RUN: outputs go to 0 immediately without waiting for a clock edge; the next character starts a fresh frame with count 1.
- frame_len 0 and frame_len 200 (MAX_CHARS 16): treated as 1 and 16 respectively; valid after 1 and 16 characters.
- With CHAR_FRAME_TERM_EN, frame_len 16, input "ab\n": count 2, valid = 1, term_seen = 1, done pulses once, buffer[2] not written.

Source files
------------

// File: rtl/char_pkg.sv
// Shared types, defaults and the frame-length clamp for char_frame_cnt.
package char_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_e;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam logic [7:0]  TERM_CHAR_DEF = 8'h0A;

    // A length of 0 means a one-character frame; oversize lengths saturate at the buffer depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_chars);
        if (len == 32'd0) return 32'd1;
        if (len > max_chars) return max_chars;
        return len;
    endfunction

endpackage

// File: rtl/char_buf.sv
// Character store: single write port, registered read port, contents not reset.
module char_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Same-address write and read in one cycle returns the pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/char_frame_cnt.sv
// Frame character counter with buffer and first-to-last cycle timing.
// Optional early terminator support under CHAR_FRAME_TERM_EN.
module char_frame_cnt
    import char_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_CHARS) + 1,
    parameter int unsigned TIME_W    = 32
`ifdef CHAR_FRAME_TERM_EN
    ,
    parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(TERM_CHAR_DEF)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [CNT_W-1:0]  count,
    output logic              valid,
    output logic              done,
    output logic              overflow,
    output logic [TIME_W-1:0] frame_cycles,
    input  logic [CNT_W-2:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
`ifdef CHAR_FRAME_TERM_EN
    ,
    output logic              term_seen
`endif
);

    localparam int unsigned AW = CNT_W - 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [TIME_W-1:0] fc_q, fc_d, fc_inc;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              is_term;
    logic              we;
    logic [AW-1:0]     waddr;

`ifdef CHAR_FRAME_TERM_EN
    logic term_q, term_d;
    assign is_term = (rx_data == TERM_CHAR);
`else
    assign is_term = 1'b0;
`endif

    assign fc_inc = (fc_q == '1) ? fc_q : fc_q + TIME_W'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        fc_d       = fc_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        waddr      = count_q[AW-1:0];
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    len_d = CNT_W'(clamp_len(32'(frame_len), MAX_CHARS));
                    fc_d  = TIME_W'(1);
                    if (is_term) begin
                        state_d = FULL;
                    end else begin
                        we      = 1'b1;
                        waddr   = '0;
                        count_d = CNT_W'(1);
                        state_d = (len_d == CNT_W'(1)) ? FULL : RUN;
                    end
                end
            end
            RUN: begin
                fc_d = fc_inc;
                if (rx_valid) begin
                    if (is_term) begin
                        state_d = FULL;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        if (count_d == len_q) state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (rx_valid) overflow_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            fc_d       = '0;
            overflow_d = 1'b0;
            we         = 1'b0;
        end
        done_d = (state_d == FULL) && (state_q != FULL);
    end

`ifdef CHAR_FRAME_TERM_EN
    always_comb begin
        term_d = term_q | (rx_valid && is_term && (state_q != FULL));
        if (clear) term_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) term_q <= 1'b0;
        else      term_q <= term_d;
    end

    assign term_seen = term_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            len_q      <= '0;
            fc_q       <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            fc_q       <= fc_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    char_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_CHARS),
        .AW     (AW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (rx_data),
        .raddr  (rd_idx),
        .rdata  (rd_data)
    );

    assign count        = count_q;
    assign valid        = (state_q == FULL);
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign frame_cycles = fc_q;

endmodule

// File: tb/tb_char_frame_cnt.sv
// Randomised and directed bench for char_frame_cnt against a frame-level model.
module tb_char_frame_cnt;

    localparam int unsigned MAXC = 16;
`ifdef CHAR_FRAME_TERM_EN
    localparam bit TERM_EN = 1'b1;
`else
    localparam bit TERM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        rx_valid = 1'b0;
    logic [4:0]  frame_len = '0;
    logic [7:0]  rx_data = '0;
    logic [3:0]  rd_idx = '0;
    logic [4:0]  count;
    logic        valid, done, overflow;
    logic [31:0] frame_cycles;
    logic [7:0]  rd_data;
`ifdef CHAR_FRAME_TERM_EN
    logic        term_seen;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit rd_rand = 1'b1;

    always #5 clk = ~clk;

    char_frame_cnt dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .frame_len    (frame_len),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .count        (count),
        .valid        (valid),
        .done         (done),
        .overflow     (overflow),
        .frame_cycles (frame_cycles),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data)
`ifdef CHAR_FRAME_TERM_EN
        ,
        .term_seen    (term_seen)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame opens on its first character, closes on length or terminator.
    logic [7:0]  m_mem [MAXC];
    bit          m_known [MAXC];
    bit          m_open, m_valid, m_done, m_ovf, m_term;
    int unsigned m_cnt, m_len, m_first, m_fc, cyc;
    logic [7:0]  exp_rd;
    bit          exp_rd_known;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_open = 0; m_valid = 0; m_done = 0; m_ovf = 0; m_term = 0;
            m_cnt = 0; m_fc = 0; exp_rd = '0; exp_rd_known = 1;
        end else begin
            cyc++;
            exp_rd       = m_mem[rd_idx];
            exp_rd_known = m_known[rd_idx];
            m_done       = 0;
            if (clear) begin
                m_open = 0; m_valid = 0; m_ovf = 0; m_term = 0; m_cnt = 0;
            end else if (rx_valid) begin
                if (m_valid) begin
                    m_ovf = 1;
                end else begin
                    if (!m_open) begin
                        m_open  = 1;
                        m_first = cyc;
                        m_len   = (frame_len == 0) ? 1 : ((frame_len > MAXC) ? MAXC : frame_len);
                    end
                    if (TERM_EN && rx_data == 8'h0A) begin
                        m_term = 1; m_valid = 1; m_done = 1;
                    end else begin
                        m_mem[m_cnt]   = rx_data;
                        m_known[m_cnt] = 1;
                        m_cnt++;
                        if (m_cnt == m_len) begin
                            m_valid = 1; m_done = 1;
                        end
                    end
                end
            end
            if (m_done)       m_fc = cyc - m_first + 1;
            else if (!m_valid) m_fc = m_open ? cyc - m_first + 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("count", count, m_cnt);
        chk("valid", valid, m_valid);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("frame_cycles", frame_cycles, m_fc);
        if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
`ifdef CHAR_FRAME_TERM_EN
        chk("term_seen", term_seen, m_term);
`endif
    end

    task automatic tick();
        @(negedge clk);
        if (rd_rand) rd_idx = 4'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input int unsigned gap);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap - 1) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [3:0] idx, input logic [7:0] exp);
        rd_rand = 1'b0;
        rd_idx  = idx;
        tick();
        chk(name, rd_data, exp);
        rd_rand = 1'b1;
    endtask

    logic [7:0] t1 [16];
    logic [7:0] t2 [6];
    logic [7:0] t5 [16];

    initial begin
        repeat (2) tick();
        chk("rst_count", count, 0);
        chk("rst_valid", valid, 0);
        chk("rst_fc", frame_cycles, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        tick();

        // Full 16-character frame, strobes 10 cycles apart
        frame_len = 5'd16;
        foreach (t1[i]) t1[i] = 8'($urandom_range(16, 255));
        for (int i = 0; i < 16; i++) begin
            send(t1[i], (i == 15) ? 1 : 10);
            chk("t1_count", count, i + 1);
        end
        chk("t1_valid", valid, 1);
        chk("t1_done", done, 1);
        chk("t1_fc", frame_cycles, 151);
        tick();
        chk("t1_done_once", done, 0);
        for (int i = 0; i < 16; i++) read_chk("t1_rd", 4'(i), t1[i]);

        // Overflow on a length-4 frame
        do_clear();
        frame_len = 5'd4;
        foreach (t2[i]) t2[i] = 8'($urandom_range(16, 255));
        for (int i = 0; i < 6; i++) begin
            send(t2[i], 2);
            if (i == 3) chk("t2_valid", valid, 1);
            if (i == 3) chk("t2_ovf_pre", overflow, 0);
            if (i == 4) chk("t2_ovf", overflow, 1);
        end
        chk("t2_count", count, 4);
        for (int i = 0; i < 4; i++) read_chk("t2_rd", 4'(i), t2[i]);

        // Clear collides with a character at count 3
        do_clear();
        frame_len = 5'd8;
        for (int i = 0; i < 3; i++) send(8'($urandom_range(16, 255)), 2);
        clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h0E;
        tick();
        clear = 1'b0; rx_valid = 1'b0;
        chk("t3_count", count, 0);
        chk("t3_fc", frame_cycles, 0);
        read_chk("t3_not_stored", 4'd3, t2[3]);

        // Asynchronous reset between clock edges mid-frame
        do_clear();
        for (int i = 0; i < 3; i++) send(8'($urandom_range(16, 255)), 2);
        #2 rst = 1'b0;
        #1;
        chk("t4_async_count", count, 0);
        chk("t4_async_fc", frame_cycles, 0);
        chk("t4_async_rd", rd_data, 0);
        tick();
        rst = 1'b1;
        send(8'h41, 2);
        chk("t4_count", count, 1);
        chk("t4_fc", frame_cycles, 2);

        // Length clamping: 0 -> 1, oversize -> 16
        do_clear();
        frame_len = 5'd0;
        send(8'h42, 1);
        chk("t5_len0_valid", valid, 1);
        chk("t5_len0_count", count, 1);
        do_clear();
        frame_len = 5'd31;
        for (int i = 0; i < 16; i++) begin
            t5[i] = 8'($urandom_range(16, 255));
            send(t5[i], 1);
            chk("t5_clamp_valid", valid, (i == 15) ? 1 : 0);
        end
        chk("t5_clamp_count", count, 16);

`ifdef CHAR_FRAME_TERM_EN
        do_clear();
        frame_len = 5'd16;
        send(8'h61, 1);
        send(8'h62, 1);
        send(8'h0A, 1);
        chk("t6_count", count, 2);
        chk("t6_valid", valid, 1);
        chk("t6_term", term_seen, 1);
        chk("t6_done", done, 1);
        tick();
        chk("t6_done_once", done, 0);
        read_chk("t6_buf2", 4'd2, t5[2]);
        do_clear();
        send(8'h0A, 1);
        chk("t6_idle_count", count, 0);
        chk("t6_idle_valid", valid, 1);
`endif

        // Random frames
        for (int f = 0; f < 60; f++) begin
            int unsigned n;
            do_clear();
            frame_len = 5'($urandom_range(0, 31));
            n = $urandom_range(0, 20);
            for (int k = 0; k < n; k++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
                if ($urandom_range(0, 29) == 0) begin
                    clear = 1'b1; rx_valid = 1'b1; rx_data = d;
                    tick();
                    clear = 1'b0; rx_valid = 1'b0;
                end else begin
                    send(d, $urandom_range(1, 3));
                end
            end
            repeat (2) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
